// File: rtl/kalman_pkg.sv
// Shared constants, collector state type and the upper-triangle index mapping
// used by the predicted-covariance collector.
package kalman_pkg;

  localparam int unsigned DBL_WIDTH = 64;
  localparam int unsigned N_DIM     = 12;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned TRI_SIZE  = N_DIM * (N_DIM + 1) / 2;
  localparam int unsigned TRI_W     = $clog2(TRI_SIZE);
  localparam int unsigned CNT_W     = $clog2(TRI_SIZE + 1);

  localparam logic [IDX_W-1:0] N_DIM_IDX = IDX_W'(N_DIM);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDone
  } coll_state_e;

  // Linear position of (row, col) in the row-major upper triangle; caller
  // guarantees row <= col < N_DIM.
  function automatic logic [TRI_W-1:0] tri_index(input logic [IDX_W-1:0] row,
                                                 input logic [IDX_W-1:0] col);
    int unsigned r;
    int unsigned c;
    int unsigned idx;
    r   = 32'(row);
    c   = 32'(col);
    // r*(r-1) wraps when r == 0 but is multiplied by zero, so the result holds
    idx = r * N_DIM - (r * (r - 1)) / 2 + (c - r);
    return TRI_W'(idx);
  endfunction

endpackage

// File: rtl/sym_tri_regfile.sv
// Symmetric matrix storage: TRI_SIZE words holding the upper triangle.
// Both ports fold (row, col) onto the upper triangle by swapping when row > col.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset (clears storage)
//   wr_row_i/wr_col_i        write coordinates
//   wr_in_range_o/wr_idx_o   combinational range flag and linear index of the write
//   wr_en_i/wr_data_i        write strobe (qualified by the owner) and data
//   rd_en_i/rd_row_i/rd_col_i read request
//   rd_data_o/rd_valid_o     registered read result, one cycle after rd_en_i
module sym_tri_regfile
  import kalman_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IDX_W-1:0]     wr_row_i,
  input  logic [IDX_W-1:0]     wr_col_i,
  output logic                 wr_in_range_o,
  output logic [TRI_W-1:0]     wr_idx_o,
  input  logic                 wr_en_i,
  input  logic [DBL_WIDTH-1:0] wr_data_i,
  input  logic                 rd_en_i,
  input  logic [IDX_W-1:0]     rd_row_i,
  input  logic [IDX_W-1:0]     rd_col_i,
  output logic [DBL_WIDTH-1:0] rd_data_o,
  output logic                 rd_valid_o
);

  logic [DBL_WIDTH-1:0] mem_q [TRI_SIZE];
  logic [DBL_WIDTH-1:0] rd_data_q;
  logic                 rd_valid_q;
  logic [TRI_W-1:0]     rd_idx;
  logic                 rd_in_range;

  always_comb begin
    wr_in_range_o = (wr_row_i < N_DIM_IDX) && (wr_col_i < N_DIM_IDX);
    rd_in_range   = (rd_row_i < N_DIM_IDX) && (rd_col_i < N_DIM_IDX);
    wr_idx_o      = (wr_row_i > wr_col_i) ? tri_index(wr_col_i, wr_row_i)
                                          : tri_index(wr_row_i, wr_col_i);
    rd_idx        = (rd_row_i > rd_col_i) ? tri_index(rd_col_i, rd_row_i)
                                          : tri_index(rd_row_i, rd_col_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < TRI_SIZE; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_o] <= wr_data_i;
    end
  end

  // Reads sample mem_q before this edge's write lands: read-before-write.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q <= rd_in_range ? mem_q[rd_idx] : '0;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/pred_cov_collector.sv
// Collects the predicted-covariance elements of one epoch into a symmetric
// register file, flags duplicate / out-of-range writes and pulses done once all
// unique elements have arrived. Reads are served in any state.
// Ports:
//   clk_i, rst_ni                     clock, synchronous active-low reset
//   start_i                           begin (or restart) a collection epoch
//   in_valid_i/in_row_i/in_col_i/in_data_i  element write
//   rd_en_i/rd_row_i/rd_col_i         read request
//   rd_data_o/rd_valid_o              read result, 1-cycle latency
//   busy_o                            collecting
//   done_o                            1-cycle pulse when the matrix is complete
//   err_dup_o/err_range_o             sticky per-epoch error flags
module pred_cov_collector
  import kalman_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 in_valid_i,
  input  logic [IDX_W-1:0]     in_row_i,
  input  logic [IDX_W-1:0]     in_col_i,
  input  logic [DBL_WIDTH-1:0] in_data_i,
  input  logic                 rd_en_i,
  input  logic [IDX_W-1:0]     rd_row_i,
  input  logic [IDX_W-1:0]     rd_col_i,
  output logic [DBL_WIDTH-1:0] rd_data_o,
  output logic                 rd_valid_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_dup_o,
  output logic                 err_range_o
);

  coll_state_e         state_q;
  logic [TRI_SIZE-1:0] bitmap_q;
  logic [CNT_W-1:0]    count_q;
  logic                done_q;
  logic                err_dup_q;
  logic                err_range_q;

  logic                wr_in_range;
  logic [TRI_W-1:0]    wr_idx;
  logic                bit_set;
  logic                collecting;
  logic                wr_attempt;
  logic                wr_accept;

  always_comb begin
    collecting = (state_q == StCollect);
    // A write coincident with start is dropped.
    wr_attempt = in_valid_i && !start_i;
    bit_set    = wr_in_range && bitmap_q[wr_idx];
    wr_accept  = wr_attempt && collecting && wr_in_range && !bit_set;
  end

  sym_tri_regfile u_regfile (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .wr_row_i      (in_row_i),
    .wr_col_i      (in_col_i),
    .wr_in_range_o (wr_in_range),
    .wr_idx_o      (wr_idx),
    .wr_en_i       (wr_accept),
    .wr_data_i     (in_data_i),
    .rd_en_i       (rd_en_i),
    .rd_row_i      (rd_row_i),
    .rd_col_i      (rd_col_i),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      bitmap_q    <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      err_dup_q   <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        state_q     <= StCollect;
        bitmap_q    <= '0;
        count_q     <= '0;
        err_dup_q   <= 1'b0;
        err_range_q <= 1'b0;
      end else if (wr_attempt) begin
        if (!collecting || !wr_in_range) begin
          err_range_q <= 1'b1;
        end else if (bit_set) begin
          err_dup_q <= 1'b1;
        end else begin
          bitmap_q[wr_idx] <= 1'b1;
          count_q          <= count_q + CNT_W'(1);
          if (count_q == CNT_W'(TRI_SIZE - 1)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
      end
    end
  end

  assign busy_o      = (state_q == StCollect);
  assign done_o      = done_q;
  assign err_dup_o   = err_dup_q;
  assign err_range_o = err_range_q;

endmodule
